// File: rtl/sdram_rd_arbiter.sv
// Two-port round-robin arbiter for the SDRAM controller read port.
// One burst of 2**RD_BL beats is outstanding at a time; the winner's handshakes are routed through.
module sdram_rd_arbiter #(
    parameter int unsigned RD_BL = 2,
    parameter int unsigned AW    = 22,
    parameter int unsigned DW    = 16
) (
    input  logic          sdram_clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic          m0_avalid_i,
    output logic          m0_aready_o,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_valid_o,
    input  logic          m0_ready_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic          m1_avalid_i,
    output logic          m1_aready_o,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_valid_o,
    input  logic          m1_ready_i,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_avalid_o,
    input  logic          rd_aready_i,
    input  logic [DW-1:0] rd_data_i,
    input  logic          rd_valid_i,
    output logic          rd_ready_o,
    output logic [1:0]    grant_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam int unsigned CW = RD_BL + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'((1 << RD_BL) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          win1;
    logic          beat_c;

    assign beat_c = rd_valid_i & rd_ready_o;

    // State register
    always_ff @(posedge sdram_clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitration, burst beat counting, stray-data flag
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        win1    = 1'b0;
        err_d   = err_q | (rd_valid_i & (state_q != DATA));
        case (state_q)
            IDLE: begin
                if (m0_avalid_i | m1_avalid_i) begin
                    win1    = (m0_avalid_i & m1_avalid_i) ? prio_q : m1_avalid_i;
                    grant_d = win1 ? 2'b10 : 2'b01;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (rd_aready_i) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_c) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        // The port that just finished yields the next tie
                        prio_d  = grant_q[0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshakes steered by the registered grant
    always_comb begin
        rd_avalid_o = 1'b0;
        rd_ready_o  = 1'b0;
        m0_aready_o = 1'b0;
        m1_aready_o = 1'b0;
        m0_valid_o  = 1'b0;
        m1_valid_o  = 1'b0;
        rd_addr_o   = grant_q[1] ? m1_addr_i : m0_addr_i;
        m0_data_o   = rd_data_i;
        m1_data_o   = rd_data_i;
        grant_o     = grant_q;
        busy_o      = (state_q != IDLE);
        err_o       = err_q;
        case (state_q)
            ADDR: begin
                rd_avalid_o = 1'b1;
                m0_aready_o = grant_q[0] & rd_aready_i;
                m1_aready_o = grant_q[1] & rd_aready_i;
            end
            DATA: begin
                rd_ready_o = (grant_q[0] & m0_ready_i) | (grant_q[1] & m1_ready_i);
                m0_valid_o = grant_q[0] & rd_valid_i;
                m1_valid_o = grant_q[1] & rd_valid_i;
            end
            default: ;
        endcase
    end

endmodule
